// File: rtl/audio_codec_spi_seq.sv
`default_nettype none
// ============================================================================
// Module      : audio_codec_spi_seq
// Description : Audio codec control-port sequencer. Pulses the codec reset,
//               plays an external init table (register writes and delays) over
//               SPI, then serves single-register runtime read/write requests.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_codec_spi_seq #(
    parameter int CLK_DIV    = 8,
    parameter int RST_CYCLES = 500,
    parameter int RST_WAIT   = 50000,
    parameter int DLY_UNIT   = 1024
) (
    input  logic        clk_50MHz,
    input  logic        reset,
    output logic        codec_reset_n,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [5:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    input  logic        req,
    input  logic        req_rnw,
    input  logic [6:0]  req_addr,
    input  logic [7:0]  req_data,
    output logic        ack,
    output logic [7:0]  rd_data,
    output logic        init_done,
    output logic        busy
);

    localparam int               DIV_W       = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(CLK_DIV - 1);
    localparam logic [31:0]      c_hold_last = 32'(RST_CYCLES - 1);
    localparam logic [31:0]      c_wait_last = 32'(RST_WAIT - 1);
    localparam logic [31:0]      c_gap_last  = 32'(CLK_DIV - 1);
    localparam logic [31:0]      c_dly_unit  = 32'(DLY_UNIT);

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_FETCH    = 3'd2,
        ST_DELAY    = 3'd3,
        ST_SHIFT    = 3'd4,
        ST_GAP      = 3'd5,
        ST_DONE     = 3'd6,
        ST_IDLE     = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;        // reset/wait/fetch/delay/gap timer
    logic [DIV_W-1:0]   div_q, div_d;        // clocks within an SCLK half
    logic [5:0]         half_q, half_d;      // SCLK half index, 0..32
    logic [15:0]        shreg_q, shreg_d;    // TX frame out of [15], RX in at [0]
    logic               mosi_en_q, mosi_en_d;
    logic               rnw_q, rnw_d;
    logic [5:0]         addr_q, addr_d;
    logic               rst_n_q, rst_n_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               ack_q, ack_d;
    logic [7:0]         rd_q, rd_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               w_advance;           // move to the next table entry
    logic               w_start;             // launch a frame with w_frame
    logic [15:0]        w_frame;

    // Next-state and output decode for the whole sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        half_d    = half_q;
        shreg_d   = shreg_q;
        mosi_en_d = mosi_en_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        ack_d     = 1'b0;
        rd_d      = rd_q;
        w_advance = 1'b0;
        w_start   = 1'b0;
        w_frame   = tbl_data;

        case (state_q)
            ST_RST_HOLD: begin
                if (cnt_q == c_hold_last) begin
                    state_d = ST_RST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_q == c_wait_last) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_FETCH: begin
                // First cycle lets the synchronous ROM respond; second decodes.
                if (cnt_q == 32'd0) begin
                    cnt_d = 32'd1;
                end else if (tbl_data == 16'hFFFF) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else if (tbl_data[8]) begin
                    if (tbl_data[7:0] == 8'd0) begin
                        w_advance = 1'b1;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = 32'(tbl_data[7:0]) * c_dly_unit - 32'd1;
                    end
                end else begin
                    w_start = 1'b1;
                end
            end
            ST_DELAY: begin
                if (cnt_q == 32'd0) begin
                    w_advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_SHIFT: begin
                if (div_q != c_div_last) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (half_q == 6'd32) begin
                        // End of the trailing low half: release the bus.
                        state_d   = ST_GAP;
                        cs_n_d    = 1'b1;
                        sclk_d    = 1'b0;
                        mosi_en_d = 1'b0;
                        cnt_d     = '0;
                    end else begin
                        half_d = half_q + 6'd1;
                        if (!half_q[0]) begin
                            sclk_d = 1'b1;
                        end else begin
                            // Last clock of a high half: capture MISO and
                            // expose the next TX bit for the coming low half.
                            sclk_d  = 1'b0;
                            shreg_d = {shreg_q[14:0], spi_miso};
                            if (half_q == 6'd31) begin
                                mosi_en_d = 1'b0;
                            end
                        end
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == c_gap_last) begin
                    cnt_d = '0;
                    if (done_q) begin
                        state_d = ST_IDLE;
                        ack_d   = 1'b1;
                        if (rnw_q) begin
                            rd_d = shreg_q[7:0];
                        end
                    end else begin
                        w_advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (req) begin
                    w_start = 1'b1;
                    w_frame = {req_addr, req_rnw, (req_rnw ? 8'h00 : req_data)};
                end
            end
            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase

        // The table never wraps: finishing entry 63 ends init.
        if (w_advance) begin
            cnt_d = '0;
            if (addr_q == 6'd63) begin
                state_d = ST_DONE;
            end else begin
                addr_d  = addr_q + 6'd1;
                state_d = ST_FETCH;
            end
        end

        if (w_start) begin
            state_d   = ST_SHIFT;
            shreg_d   = w_frame;
            rnw_d     = w_frame[8];
            cs_n_d    = 1'b0;
            sclk_d    = 1'b0;
            mosi_en_d = 1'b1;
            div_d     = '0;
            half_d    = '0;
        end

        rst_n_d = (state_d != ST_RST_HOLD);
        busy_d  = (state_d != ST_IDLE);
        done_d  = done_q | (state_d == ST_DONE);
    end

    // State and registered outputs; reset forces the pins safe immediately.
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RST_HOLD;
            cnt_q     <= '0;
            div_q     <= '0;
            half_q    <= '0;
            shreg_q   <= '0;
            mosi_en_q <= 1'b0;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            rst_n_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            ack_q     <= 1'b0;
            rd_q      <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            half_q    <= half_d;
            shreg_q   <= shreg_d;
            mosi_en_q <= mosi_en_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            rst_n_q   <= rst_n_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            ack_q     <= ack_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign codec_reset_n = rst_n_q;
    assign spi_cs_n      = cs_n_q;
    assign spi_sclk      = sclk_q;
    assign spi_mosi      = shreg_q[15] & mosi_en_q;
    assign tbl_addr      = addr_q;
    assign ack           = ack_q;
    assign rd_data       = rd_q;
    assign init_done     = done_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_codec_spi_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_codec_spi_seq
// Description : Self-checking bench for audio_codec_spi_seq: SPI frame monitor,
//               MISO responder, init-table ROM model and runtime request model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_codec_spi_seq;

    localparam int CLK_DIV    = 4;
    localparam int RST_CYCLES = 10;
    localparam int RST_WAIT   = 20;
    localparam int DLY_UNIT   = 16;
    localparam int FRAME_LOW  = 33 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        codec_reset_n, spi_cs_n, spi_sclk, spi_mosi;
    logic        spi_miso = 1'b0;
    logic [5:0]  tbl_addr;
    logic [15:0] tbl_data = 16'hFFFF;
    logic        req = 1'b0, req_rnw = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [7:0]  req_data = '0;
    logic        ack, init_done, busy;
    logic [7:0]  rd_data;

    audio_codec_spi_seq #(
        .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES),
        .RST_WAIT(RST_WAIT), .DLY_UNIT(DLY_UNIT)
    ) dut (
        .clk_50MHz(clk), .reset(reset), .codec_reset_n(codec_reset_n),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .req(req), .req_rnw(req_rnw), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .rd_data(rd_data), .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous init-table ROM.
    logic [15:0] rom [64];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0, n_chk = 0, n_fail = 0;
    int rel;
    logic [7:0] miso_byte = 8'h00;
    logic [7:0] exp_rd = 8'h00;

    // Monitor state, sampled 1 time unit after every rising clock.
    logic [15:0] frames[$];
    int          lows[$], nbits[$];
    logic [15:0] mon_sh = '0;
    int          mon_bits = 0, mon_low = 0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_rstn = 1'b0;
    logic        prev_done = 1'b0, prev_busy = 1'b1;
    int          cs_fall = -1, cs_rise = -1, rstn_rise = -1, done_rise = -1;
    int          busy_fall = -1, ack_cyc = -1, ack_cnt = 0;
    logic [7:0]  ack_rd = '0;
    logic        mosi_rise = 1'b0;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; prev_rstn = 1'b0;
            prev_done = 1'b0; prev_busy = 1'b1;
            mon_bits = 0; mon_low = 0;
        end else begin
            if (prev_cs && !spi_cs_n) begin
                mon_bits = 0; mon_low = 0; mon_sh = '0; cs_fall = cyc;
            end
            if (!spi_cs_n) mon_low++;
            if (!spi_cs_n && spi_sclk && !prev_sclk) begin
                mon_sh   = {mon_sh[14:0], spi_mosi};
                spi_miso = (mon_bits >= 8 && mon_bits <= 15) ? miso_byte[3'(15 - mon_bits)] : 1'b0;
                mon_bits++;
            end
            if (!prev_cs && spi_cs_n) begin
                frames.push_back(mon_sh); lows.push_back(mon_low); nbits.push_back(mon_bits);
                cs_rise = cyc; mosi_rise = spi_mosi;
            end
            if (!prev_rstn && codec_reset_n) rstn_rise = cyc;
            if (!prev_done && init_done) done_rise = cyc;
            if (prev_busy && !busy) busy_fall = cyc;
            if (ack) begin ack_cnt++; ack_cyc = cyc; ack_rd = rd_data; end
            prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_rstn = codec_reset_n;
            prev_done = init_done; prev_busy = busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] exp);
        logic [15:0] f = 'x;
        int lw = -1, nb = -1;
        if (frames.size() > 0) begin
            f = frames.pop_front(); lw = lows.pop_front(); nb = nbits.pop_front();
        end
        check({tag, "_frame"}, 32'(f), 32'(exp));
        check({tag, "_cslow"}, lw, FRAME_LOW);
        check({tag, "_bits"}, nb, 16);
    endtask

    task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
        rom[0] = e0; rom[1] = e1; rom[2] = e2;
    endtask

    task automatic release_reset();
        repeat (3) @(negedge clk);
        frames.delete(); lows.delete(); nbits.delete();
        exp_rd = 8'h00;
        reset = 1'b0;
        rel = cyc;
    endtask

    task automatic full_reset();
        @(negedge clk);
        reset = 1'b1; req = 1'b0;
        release_reset();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!init_done && n < 5000) begin @(negedge clk); n++; end
        check({tag, "_done_seen"}, 32'(init_done), 32'd1);
    endtask

    task automatic wait_ack(input int a0, input string tag);
        int n = 0;
        while (ack_cnt == a0 && n < 2000) begin @(negedge clk); n++; end
        check({tag, "_ack_seen"}, 32'(ack_cnt != a0), 32'd1);
    endtask

    task automatic wait_cs_low(input string tag);
        int n = 0;
        while (spi_cs_n && n < 2000) begin @(negedge clk); n++; end
        check({tag, "_cs_low_seen"}, 32'(spi_cs_n), 32'd0);
    endtask

    // One runtime request; the model derives frame and read-back from the rules.
    task automatic do_req(input logic rnw, input logic [6:0] a, input logic [7:0] d,
                          input logic [7:0] mb, input string tag);
        int c0, a0;
        logic [15:0] ef;
        miso_byte = mb;
        ef = {a, rnw, (rnw ? 8'h00 : d)};
        if (rnw) exp_rd = mb;
        a0 = ack_cnt;
        @(negedge clk);
        req = 1'b1; req_rnw = rnw; req_addr = a; req_data = d; c0 = cyc;
        wait_ack(a0, tag);
        req = 1'b0;
        check({tag, "_cs_lat"}, cs_fall, c0 + 1);
        check_frame(tag, ef);
        check({tag, "_mosi_idle"}, 32'(mosi_rise), 32'd0);
        check({tag, "_ack_lat"}, ack_cyc - cs_rise, CLK_DIV);
        check({tag, "_rd"}, 32'(ack_rd), 32'(exp_rd));
        repeat (6) @(negedge clk);
        check({tag, "_one_ack"}, ack_cnt, a0 + 1);
        check({tag, "_no_extra"}, frames.size(), 0);
    endtask

    logic        r_rnw;
    logic [6:0]  r_addr;
    logic [7:0]  r_data, r_mb;
    int          a_b2b, k_b2b;

    initial begin
        // Reset state.
        load_rom(16'h0001, 16'h0280, 16'hFFFF);
        repeat (3) @(negedge clk);
        check("rst_codec_reset_n", 32'(codec_reset_n), 32'd0);
        check("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check("rst_sclk", 32'(spi_sclk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_tbl_addr", 32'(tbl_addr), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Two-write init table.
        release_reset();
        wait_cs_low("A");
        check("A_rstn_rise", rstn_rise, rel + RST_CYCLES);
        check("A_first_cs", cs_fall, rstn_rise + RST_WAIT + 2);
        wait_done("A");
        repeat (2) @(negedge clk);
        check("A_done_time", done_rise, rel + RST_CYCLES + RST_WAIT + 2 * (2 + 34 * CLK_DIV) + 2);
        check("A_busy_fall", busy_fall - done_rise, 1);
        check("A_tbl_addr", 32'(tbl_addr), 32'd2);
        check_frame("A0", 16'h0001);
        check_frame("A1", 16'h0280);
        check("A_extra", frames.size(), 0);

        // Directed read then write.
        do_req(1'b1, 7'h2A, 8'h00, 8'hA5, "RD");
        do_req(1'b0, 7'h10, 8'h33, 8'h5C, "WR");

        // Randomized runtime requests.
        for (int i = 0; i < 6; i++) begin
            r_rnw  = 1'($urandom_range(0, 1));
            r_addr = 7'($urandom);
            r_data = 8'($urandom);
            r_mb   = 8'($urandom);
            do_req(r_rnw, r_addr, r_data, r_mb, "RND");
        end

        // req held high through ack starts a second frame on the next clock.
        miso_byte = 8'h00;
        a_b2b = ack_cnt;
        @(negedge clk);
        req = 1'b1; req_rnw = 1'b0; req_addr = 7'h05; req_data = 8'h5A;
        wait_ack(a_b2b, "B2B1");
        k_b2b = ack_cyc;
        @(negedge clk);
        req = 1'b0;
        check("B2B_restart", cs_fall, k_b2b + 1);
        wait_ack(a_b2b + 1, "B2B2");
        repeat (6) @(negedge clk);
        check("B2B_acks", ack_cnt, a_b2b + 2);
        check_frame("B2B0", 16'h0A5A);
        check_frame("B2B1", 16'h0A5A);

        // Delay entry only.
        load_rom(16'h0105, 16'hFFFF, 16'hFFFF);
        full_reset();
        wait_done("DLY");
        check("DLY_no_spi", frames.size(), 0);
        check("DLY_window", 32'((done_rise - (rel + RST_CYCLES + RST_WAIT + 2)) >= 5 * DLY_UNIT - 2 &&
                                (done_rise - (rel + RST_CYCLES + RST_WAIT + 2)) <= 5 * DLY_UNIT + 2), 32'd1);
        check("DLY_tbl_addr", 32'(tbl_addr), 32'd1);

        // Zero-length delays filling the table with no end marker.
        for (int i = 0; i < 64; i++) rom[i] = 16'h0100;
        full_reset();
        wait_done("OVR");
        check("OVR_done_time", done_rise, rel + RST_CYCLES + RST_WAIT + 64 * 2);
        check("OVR_tbl_addr", 32'(tbl_addr), 32'd63);
        check("OVR_no_spi", frames.size(), 0);

        // Request raised during init waits for the table to finish.
        load_rom(16'h0001, 16'h0280, 16'hFFFF);
        full_reset();
        while (cyc < rel + 5) @(negedge clk);
        a_b2b = ack_cnt;
        r_addr = 7'($urandom); r_data = 8'($urandom);
        req = 1'b1; req_rnw = 1'b0; req_addr = r_addr; req_data = r_data;
        wait_done("INIT_REQ");
        check("INIT_REQ_frames_at_done", frames.size(), 2);
        check("INIT_REQ_no_early_ack", ack_cnt, a_b2b);
        wait_ack(a_b2b, "INIT_REQ");
        req = 1'b0;
        check("INIT_REQ_after_done", cs_fall, done_rise + 2);
        repeat (6) @(negedge clk);
        check("INIT_REQ_one_ack", ack_cnt, a_b2b + 1);
        check_frame("INIT_REQ0", 16'h0001);
        check_frame("INIT_REQ1", 16'h0280);
        check_frame("INIT_REQ2", {r_addr, 1'b0, r_data});

        // Asynchronous reset in the middle of a frame.
        full_reset();
        k_b2b = 0;
        while (!(mon_bits == 8 && !spi_cs_n) && k_b2b < 2000) begin @(negedge clk); k_b2b++; end
        check("ARST_bit7_reached", 32'(mon_bits), 32'd8);
        reset = 1'b1;
        #1;
        check("ARST_cs_n", 32'(spi_cs_n), 32'd1);
        check("ARST_sclk", 32'(spi_sclk), 32'd0);
        check("ARST_codec_rst", 32'(codec_reset_n), 32'd0);
        check("ARST_tbl_addr", 32'(tbl_addr), 32'd0);
        release_reset();
        wait_cs_low("ARST");
        check("ARST_rstn_rise", rstn_rise, rel + RST_CYCLES);
        wait_done("ARST");
        check_frame("ARST0", 16'h0001);
        check_frame("ARST1", 16'h0280);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/audio_codec_spi_seq.md
# audio_codec_spi_seq

Sequencer and arbiter for the SPI control port of the board's audio codec. After reset it pulses the codec reset pin, then steps through an external init table of register writes and delay entries. Once the table is finished, it serves single-register write or read requests from the core, for example volume or mute changes. It is the only driver of the codec SPI pins and codec reset, and it sits beside the I2S serializer in the board top level.

## Interface
- CLK_DIV, default 8: system clocks per SCLK half-period (must be ≥2). SCLK frequency = clk / (2·CLK_DIV).
- RST_CYCLES, default 500: clocks that codec_reset_n is held low after reset.
- RST_WAIT, default 50000: clocks to wait after codec_reset_n rises, before the first table fetch.
- DLY_UNIT, default 1024: clocks per count of a delay entry.

Ports:
- clk_50MHz, in, 1: sole clock.
- reset, in, 1: asynchronous, active-high reset.
- codec_reset_n, out, 1: codec hardware reset.
- spi_cs_n, out, 1: SPI chip select.
- spi_sclk, out, 1: SPI clock.
- spi_mosi, out, 1: SPI data out.
- spi_miso, in, 1: SPI data in.
- tbl_addr, out, 6: init table index.
- tbl_data, in, 16: table entry. The entry is valid 1 clock after tbl_addr changes (synchronous ROM).
- req, in, 1: runtime request (level).
- req_rnw, in, 1: 1 = read, 0 = write.
- req_addr, in, 7: codec register address.
- req_data, in, 8: write data.
- ack, out, 1: one-cycle completion pulse.
- rd_data, out, 8: last read result.
- init_done, out, 1: table finished.
- busy, out, 1: high in every state except IDLE.

## Operation
SPI frame:
- Each frame is 16 bits, MSB first: {addr[6:0], rnw, data[7:0]}.
- For reads, the data field is sent as 0x00.

Table entry format, decoded in this priority order:
- 16'hFFFF: end marker.
- Bit 8 = 1: delay entry. Wait tbl_data[7:0]·DLY_UNIT clocks. No SPI activity.
- Otherwise: write of tbl_data[7:0] to register tbl_data[15:9].

States and transitions:
- RST_HOLD: codec_reset_n = 0 for RST_CYCLES clocks, then go to RST_WAIT.
- RST_WAIT: codec_reset_n = 1. Wait RST_WAIT clocks, then go to FETCH.
- FETCH: present tbl_addr, wait 1 clock, then decode the entry:
  - End marker → DONE.
  - Delay entry → DELAY.
  - Write entry → SHIFT.
- DELAY: count down the delay, then tbl_addr+1 → FETCH.
- SHIFT: run one frame, then go to GAP.
- GAP: spi_cs_n high for CLK_DIV clocks. Then:
  - If in init: tbl_addr+1 → FETCH.
  - If serving a runtime request: pulse ack → IDLE.
- DONE: set init_done = 1 (sticky until reset) → IDLE.
- IDLE: if req is high, latch req_rnw, req_addr and req_data → SHIFT.

Boundary rules:
- Table overrun: after entry 63 is executed with no end marker, go to DONE. tbl_addr does not wrap.
- req during init: not accepted until IDLE. Because req is a level, the request is not lost.
- req held high after ack: a second transaction starts on the clock after ack. The requester must drop req in the ack cycle.
- Delay count of 0: zero wait, advance immediately.
- rd_data updates only on completion of a read. Writes leave it unchanged.

## Timing
Reset values:
- codec_reset_n = 0, spi_cs_n = 1, spi_sclk = 0, spi_mosi = 0.
- tbl_addr = 0, ack = 0, rd_data = 0x00, init_done = 0, busy = 1.
- State = RST_HOLD.

Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). The frame is abandoned.

SHIFT phase, per bit:
- Low half of CLK_DIV clocks: spi_mosi is driven at the start of this half.
- High half of CLK_DIV clocks.
- The codec samples on the rising edge.
- The block samples spi_miso on the last clock of each high half.

Frame timing:
- spi_cs_n falls on SHIFT entry.
- After bit 0 there is a trailing low half of CLK_DIV clocks, then spi_cs_n rises.
- spi_cs_n is low for exactly 33·CLK_DIV clocks.
- spi_mosi returns to 0 when spi_cs_n rises.

Runtime request latency:
- From req sampled high in IDLE to spi_cs_n low: 1 clock.
- From spi_cs_n rise to ack: CLK_DIV clocks.
- rd_data is valid in the ack cycle.

Init timing with no delay entries: the table takes (RST_CYCLES + RST_WAIT) plus, per write entry, (2 + 34·CLK_DIV) clocks. The end-marker fetch adds 2 clocks.

## Test plan
All scenarios use CLK_DIV=4, RST_CYCLES=10, RST_WAIT=20, DLY_UNIT=16.

- Reset release: codec_reset_n is low for exactly 10 clocks. The first spi_cs_n fall happens 20 + 2 clocks after codec_reset_n rises.
- Table {0x0001, 0x0280, 0xFFFF}: the SPI monitor sees frames 0x0001 and then 0x0280. tbl_addr stops at 2. init_done rises, and busy falls 1 clock later.
- Table {0x0105, 0xFFFF}: no SPI activity. DONE is reached 5·16 = 80 clocks after the delay entry is decoded (±2 for fetch).
- Read test: read req with addr 0x2A while the MISO model returns 0xA5 during the data field. The MOSI frame is 0x5500. ack pulses once and rd_data = 0xA5. A following write of 0x33 to addr 0x10 sends frame 0x2033 and leaves rd_data = 0xA5.
- Request during init: req is asserted at clock 5, before the table ends. No extra frame appears before init_done. The request frame follows DONE, with exactly one ack.
- Async reset asserted at SCLK bit 7 of a frame: spi_cs_n is 1 and spi_sclk is 0 in the same cycle. The sequence restarts from RST_HOLD with tbl_addr = 0.
